feature_extractor_cfg: RTL and testbench

- Parametrised successor to the fixed 32x32 feature extractor.
- Pipeline: 3x3 convolution with runtime-loaded signed weights and bias, optional ReLU, 2x2 stride-2 pooling with max or average mode, over a raster-streamed 8-bit image of parametrised size.
- Sits between the pixel source and the classifier/accumulator stage.
- Emits pooled results in raster order, then a single done pulse per frame.

---
 rtl/feature_extractor_cfg.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_feature_extractor_cfg.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_extractor_cfg.sv
`default_nettype none
// ============================================================================
// Module   : feature_extractor_cfg
// Brief    : Streaming 3x3 convolution (runtime weights + bias), optional ReLU
//            and 2x2 stride-2 max/average pooling over a raster 8-bit image
//            of parametrised size. Emits pooled results in raster order and
//            one done pulse per frame.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module feature_extractor_cfg #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int DATA_W     = 8,
  parameter int COEF_W     = 8,
  parameter int OUT_W      = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_signal,
  input  logic                     cfg_relu_en,
  input  logic                     cfg_pool_avg,
  input  logic                     coef_valid_in,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic                     pixel_valid_in,
  input  logic [DATA_W-1:0]        pixel_in,
  output logic                     busy,
  output logic signed [OUT_W-1:0]  final_result_out,
  output logic                     final_result_valid,
  output logic                     final_done_signal
);

  // Conv grid, pool grid and derived widths
  localparam int c_cw        = IMG_WIDTH - 2;
  localparam int c_ch        = IMG_HEIGHT - 2;
  localparam int c_pw        = c_cw / 2;
  localparam int c_ph        = c_ch / 2;
  localparam int c_res_total = c_pw * c_ph;
  localparam int c_xw        = $clog2(IMG_WIDTH);
  localparam int c_yw        = $clog2(IMG_HEIGHT);
  localparam int c_pbw       = (c_pw > 1) ? $clog2(c_pw) : 1;
  localparam int c_rw        = $clog2(c_res_total + 1);
  localparam int c_sw        = OUT_W + 2;  // room for a sum of four conv values
  localparam int c_pw_full   = COEF_W + DATA_W + 1;

  localparam logic [c_xw-1:0] c_x_last  = c_xw'(IMG_WIDTH - 1);
  localparam logic [c_yw-1:0] c_y_last  = c_yw'(IMG_HEIGHT - 1);
  localparam logic [c_rw-1:0] c_res_end = c_rw'(c_res_total);

  generate
    if (OUT_W < DATA_W + COEF_W + 5) begin : g_out_w_check
      $error("feature_extractor_cfg: OUT_W too narrow for full-precision conv");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Configuration and coefficients
  logic                     r_relu;
  logic                     r_avg;
  logic [3:0]               r_coef_cnt;
  logic signed [COEF_W-1:0] r_w [0:8];
  logic signed [COEF_W-1:0] r_bias;

  // Pixel position and line buffering
  logic [c_xw-1:0]   r_x;
  logic [c_yw-1:0]   r_y;
  logic [DATA_W-1:0] r_lb0 [0:IMG_WIDTH-1];  // row y-1
  logic [DATA_W-1:0] r_lb1 [0:IMG_WIDTH-1];  // row y-2
  logic [DATA_W-1:0] r_win [0:2][0:2];
  logic              r_win_v;
  logic              r_win_col_odd;
  logic              r_win_row_odd;
  logic [c_pbw-1:0]  r_win_pidx;

  // Conv stage
  logic signed [OUT_W-1:0] w_conv_sum;
  logic signed [OUT_W-1:0] w_conv_act;
  logic signed [OUT_W-1:0] r_conv;
  logic                    r_conv_v;
  logic                    r_conv_col_odd;
  logic                    r_conv_row_odd;
  logic [c_pbw-1:0]        r_conv_pidx;

  // Horizontal pooling stage
  logic signed [c_sw-1:0] w_conv_ext;
  logic signed [c_sw-1:0] w_h;
  logic signed [c_sw-1:0] r_hold;
  logic signed [c_sw-1:0] r_h;
  logic                   r_h_v;
  logic                   r_h_row_odd;
  logic [c_pbw-1:0]       r_h_idx;

  // Vertical pooling stage
  logic signed [c_sw-1:0]  r_pbuf [0:c_pw-1];
  logic signed [c_sw-1:0]  w_v_sum;
  logic signed [OUT_W-1:0] w_pool;
  logic [c_rw-1:0]         r_res_cnt;

  logic w_start;
  logic w_coef_acc;
  logic w_pix_acc;
  logic w_last_pix;
  logic w_frame_done;

  assign w_start      = (r_state == S_IDLE) && start_signal;
  assign w_coef_acc   = (r_state == S_LOAD) && coef_valid_in;
  assign w_pix_acc    = (r_state == S_RUN) && pixel_valid_in;
  assign w_last_pix   = (r_x == c_x_last) && (r_y == c_y_last);
  assign w_frame_done = (r_res_cnt == c_res_end);
  assign busy         = (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic: FLUSH ends once every pooled result has been emitted
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_signal) w_state_nxt = S_LOAD;
      S_LOAD:  if (coef_valid_in && (r_coef_cnt == 4'd9)) w_state_nxt = S_RUN;
      S_RUN:   if (pixel_valid_in && w_last_pix) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_frame_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch config on start; collect 9 weights then the bias during LOAD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_relu     <= 1'b0;
      r_avg      <= 1'b0;
      r_coef_cnt <= '0;
      r_bias     <= '0;
      for (int i = 0; i < 9; i++) r_w[i] <= '0;
    end else if (w_start) begin
      r_relu     <= cfg_relu_en;
      r_avg      <= cfg_pool_avg;
      r_coef_cnt <= '0;
    end else if (w_coef_acc) begin
      if (r_coef_cnt == 4'd9) begin
        r_bias     <= coef_in;
        r_coef_cnt <= '0;
      end else begin
        r_w[r_coef_cnt] <= coef_in;
        r_coef_cnt      <= r_coef_cnt + 4'd1;
      end
    end
  end

  // Raster position, line buffers and 3x3 window shift on each accepted pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x           <= '0;
      r_y           <= '0;
      r_win_v       <= 1'b0;
      r_win_col_odd <= 1'b0;
      r_win_row_odd <= 1'b0;
      r_win_pidx    <= '0;
      for (int i = 0; i < IMG_WIDTH; i++) begin
        r_lb0[i] <= '0;
        r_lb1[i] <= '0;
      end
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
    end else begin
      r_win_v <= w_pix_acc && (r_x >= c_xw'(2)) && (r_y >= c_yw'(2));
      if (w_start) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_pix_acc) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= r_lb1[r_x];
        r_win[1][2] <= r_lb0[r_x];
        r_win[2][2] <= pixel_in;
        r_lb1[r_x]  <= r_lb0[r_x];
        r_lb0[r_x]  <= pixel_in;
        // conv coordinate is (x-2, y-2): same parity as (x, y)
        r_win_col_odd <= r_x[0];
        r_win_row_odd <= r_y[0];
        r_win_pidx    <= c_pbw'((r_x - c_xw'(2)) >> 1);
        if (r_x == c_x_last) begin
          r_x <= '0;
          r_y <= (r_y == c_y_last) ? '0 : r_y + c_yw'(1);
        end else begin
          r_x <= r_x + c_xw'(1);
        end
      end
    end
  end

  // One tap: signed weight times zero-extended pixel, sign-extended to OUT_W
  function automatic logic signed [OUT_W-1:0] f_tap(
    input logic signed [COEF_W-1:0] w,
    input logic [DATA_W-1:0]        p
  );
    logic signed [c_pw_full-1:0] v_w;
    logic signed [c_pw_full-1:0] v_p;
    logic signed [c_pw_full-1:0] v_prod;
    v_w    = {{(DATA_W+1){w[COEF_W-1]}}, w};
    v_p    = {{COEF_W{1'b0}}, p};
    v_prod = v_w * v_p;
    return {{(OUT_W-c_pw_full){v_prod[c_pw_full-1]}}, v_prod};
  endfunction

  // Full-precision 3x3 MAC plus bias, then optional ReLU
  always_comb begin
    w_conv_sum = {{(OUT_W-COEF_W){r_bias[COEF_W-1]}}, r_bias};
    for (int i = 0; i < 9; i++)
      w_conv_sum = w_conv_sum + f_tap(r_w[i], r_win[i/3][i%3]);
    w_conv_act = (r_relu && w_conv_sum[OUT_W-1]) ? '0 : w_conv_sum;
  end

  // Register the conv result together with its pooling coordinates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conv         <= '0;
      r_conv_v       <= 1'b0;
      r_conv_col_odd <= 1'b0;
      r_conv_row_odd <= 1'b0;
      r_conv_pidx    <= '0;
    end else begin
      r_conv_v <= r_win_v;
      if (r_win_v) begin
        r_conv         <= w_conv_act;
        r_conv_col_odd <= r_win_col_odd;
        r_conv_row_odd <= r_win_row_odd;
        r_conv_pidx    <= r_win_pidx;
      end
    end
  end

  // Horizontal pair combine: max or sum of the even/odd conv columns
  always_comb begin
    w_conv_ext = {{2{r_conv[OUT_W-1]}}, r_conv};
    if (r_avg)                    w_h = r_hold + w_conv_ext;
    else if (r_hold > w_conv_ext) w_h = r_hold;
    else                          w_h = w_conv_ext;
  end

  // Even columns park in r_hold; odd columns produce a horizontal partial.
  // A trailing odd conv column only ever lands in r_hold and is never used.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold      <= '0;
      r_h         <= '0;
      r_h_v       <= 1'b0;
      r_h_row_odd <= 1'b0;
      r_h_idx     <= '0;
    end else begin
      r_h_v <= r_conv_v && r_conv_col_odd;
      if (r_conv_v) begin
        if (!r_conv_col_odd) begin
          r_hold <= w_conv_ext;
        end else begin
          r_h         <= w_h;
          r_h_row_odd <= r_conv_row_odd;
          r_h_idx     <= r_conv_pidx;
        end
      end
    end
  end

  // Vertical combine against the stored even-row partial
  always_comb begin
    w_v_sum = r_pbuf[r_h_idx] + r_h;
    if (r_avg)                        w_pool = OUT_W'(w_v_sum >>> 2);
    else if (r_pbuf[r_h_idx] > r_h)   w_pool = OUT_W'(r_pbuf[r_h_idx]);
    else                              w_pool = OUT_W'(r_h);
  end

  // Even rows fill the pool row buffer; odd rows emit a pooled result.
  // A trailing odd conv row only writes the buffer and is never emitted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      final_result_out   <= '0;
      final_result_valid <= 1'b0;
      r_res_cnt          <= '0;
      for (int i = 0; i < c_pw; i++) r_pbuf[i] <= '0;
    end else begin
      final_result_valid <= r_h_v && r_h_row_odd;
      if (r_h_v) begin
        if (!r_h_row_odd) r_pbuf[r_h_idx] <= r_h;
        else              final_result_out <= w_pool;
      end
      if (w_start)                  r_res_cnt <= '0;
      else if (r_h_v && r_h_row_odd) r_res_cnt <= r_res_cnt + c_rw'(1);
    end
  end

  // Done pulse the cycle after the last result, as FLUSH returns to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) final_done_signal <= 1'b0;
    else      final_done_signal <= (r_state == S_FLUSH) && w_frame_done;
  end

endmodule
`default_nettype wire

// File: tb/tb_feature_extractor_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_feature_extractor_cfg
// Brief    : Self-checking bench for feature_extractor_cfg (8x8, 7x7, 32x32
//            instances) against a direct convolution/pooling reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_feature_extractor_cfg;

  typedef struct {
    int val;
    int px;  // completing pixel column
    int py;  // completing pixel row
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] start_v;
  logic cfg_relu_en, cfg_pool_avg, coef_valid_in, pixel_valid_in;
  logic signed [7:0] coef_in;
  logic [7:0] pixel_in;

  logic signed [21:0] res [3];
  logic vld [3];
  logic dn  [3];
  logic bsy [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int img [0:31][0:31];
  int acc_cyc [0:31][0:31];
  int wt [0:9];
  int mW, mH, sel;
  bit m_relu, m_avg;
  exp_t exp_q[$];
  exp_t e_cur;
  int got_log[$];
  int last_vld_cyc = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  feature_extractor_cfg #(.IMG_WIDTH(8), .IMG_HEIGHT(8)) u8 (
    .clk(clk), .rst(rst), .start_signal(start_v[0]), .cfg_relu_en(cfg_relu_en),
    .cfg_pool_avg(cfg_pool_avg), .coef_valid_in(coef_valid_in), .coef_in(coef_in),
    .pixel_valid_in(pixel_valid_in), .pixel_in(pixel_in), .busy(bsy[0]),
    .final_result_out(res[0]), .final_result_valid(vld[0]), .final_done_signal(dn[0]));

  feature_extractor_cfg #(.IMG_WIDTH(7), .IMG_HEIGHT(7)) u7 (
    .clk(clk), .rst(rst), .start_signal(start_v[1]), .cfg_relu_en(cfg_relu_en),
    .cfg_pool_avg(cfg_pool_avg), .coef_valid_in(coef_valid_in), .coef_in(coef_in),
    .pixel_valid_in(pixel_valid_in), .pixel_in(pixel_in), .busy(bsy[1]),
    .final_result_out(res[1]), .final_result_valid(vld[1]), .final_done_signal(dn[1]));

  feature_extractor_cfg u32 (
    .clk(clk), .rst(rst), .start_signal(start_v[2]), .cfg_relu_en(cfg_relu_en),
    .cfg_pool_avg(cfg_pool_avg), .coef_valid_in(coef_valid_in), .coef_in(coef_in),
    .pixel_valid_in(pixel_valid_in), .pixel_in(pixel_in), .busy(bsy[2]),
    .final_result_out(res[2]), .final_result_valid(vld[2]), .final_done_signal(dn[2]));

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference convolution at conv coordinate (cx, cy)
  function automatic int conv_at(input int cx, input int cy);
    int s;
    s = wt[9];
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += wt[r*3+c] * img[cy+r][cx+c];
    if (m_relu && s < 0) s = 0;
    return s;
  endfunction

  // Expected pooled results in raster order with their completing pixel
  function automatic void build_expect();
    int a, b, c, d, v;
    for (int py = 0; py < (mH-2)/2; py++)
      for (int px = 0; px < (mW-2)/2; px++) begin
        a = conv_at(2*px, 2*py);   b = conv_at(2*px+1, 2*py);
        c = conv_at(2*px, 2*py+1); d = conv_at(2*px+1, 2*py+1);
        if (m_avg) v = (a + b + c + d) >>> 2;
        else begin
          v = a;
          if (b > v) v = b;
          if (c > v) v = c;
          if (d > v) v = d;
        end
        exp_q.push_back('{val: v, px: 2*px+3, py: 2*py+3});
      end
  endfunction

  // Compare process: every strobe and done pulse of every instance
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        if (vld[i]) begin
          if (i != sel || exp_q.size() == 0) begin
            chk(1'b0, "spurious_valid", i, sel);
          end else begin
            e_cur = exp_q.pop_front();
            chk(int'(res[i]) == e_cur.val, "result_value", res[i], e_cur.val);
            chk(cyc == acc_cyc[e_cur.py][e_cur.px] + 3, "result_latency",
                cyc, acc_cyc[e_cur.py][e_cur.px] + 3);
            got_log.push_back(int'(res[i]));
            last_vld_cyc = cyc;
          end
        end
        if (dn[i]) begin
          done_cnt++;
          chk(i == sel, "done_instance", i, sel);
          chk(exp_q.size() == 0, "done_before_results", exp_q.size(), 0);
          if (i != 1) chk(cyc == last_vld_cyc + 1, "done_timing", cyc, last_vld_cyc + 1);
          chk(bsy[i] == 1'b0, "busy_at_done", bsy[i], 0);
        end
      end
    end
  end

  task automatic idle_cycle();
    coef_valid_in  = 1'b0;
    pixel_valid_in = 1'b0;
    @(negedge clk);
  endtask

  // Drive one frame on instance inst; abort_after>0 stops after that many pixels
  task automatic run_frame(input int inst, input int w, input int h, input int gap_pct,
                           input int abort_after, input bit extra);
    int n_exp, d0, t, npix;
    sel = inst; mW = w; mH = h;
    got_log.delete();
    exp_q.delete();
    build_expect();
    n_exp = exp_q.size();
    d0 = done_cnt;
    cfg_relu_en = m_relu; cfg_pool_avg = m_avg;
    start_v[inst] = 1'b1;
    @(negedge clk);
    start_v = '0;
    cfg_relu_en = $urandom_range(1); cfg_pool_avg = $urandom_range(1);
    for (int k = 0; k < 10; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        coef_valid_in = 1'b0;
        pixel_valid_in = $urandom_range(1);
        pixel_in = 8'($urandom);
        @(negedge clk);
      end
      coef_valid_in = 1'b1;
      coef_in = 8'(wt[k]);
      pixel_valid_in = 1'b0;
      @(negedge clk);
    end
    coef_valid_in = 1'b0;
    npix = 0;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (abort_after == 0 || npix < abort_after) begin
          while ($urandom_range(99) < gap_pct) begin
            pixel_valid_in = 1'b0;
            coef_valid_in = $urandom_range(1);
            coef_in = 8'($urandom);
            pixel_in = 8'($urandom);
            @(negedge clk);
          end
          pixel_valid_in = 1'b1;
          pixel_in = 8'(img[y][x]);
          coef_valid_in = $urandom_range(1);
          coef_in = 8'($urandom);
          start_v[inst] = ($urandom_range(15) == 0);
          acc_cyc[y][x] = cyc + 1;
          npix++;
          @(negedge clk);
          start_v = '0;
        end
      end
    end
    pixel_valid_in = 1'b0;
    coef_valid_in = 1'b0;
    if (abort_after == 0) begin
      t = 0;
      while (done_cnt == d0 && t < 400) begin
        pixel_valid_in = extra && (t < 20);
        pixel_in = 8'($urandom);
        @(negedge clk);
        t++;
      end
      chk(done_cnt != d0, "done_timeout", done_cnt - d0, 1);
      repeat (25) idle_cycle();
      chk(done_cnt - d0 == 1, "done_pulse_count", done_cnt - d0, 1);
      chk(got_log.size() == n_exp, "result_count", got_log.size(), n_exp);
    end
  endtask

  task automatic set_identity();
    for (int k = 0; k < 10; k++) wt[k] = (k == 4) ? 1 : 0;
  endtask

  task automatic set_ramp(input int w, input int h);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) img[y][x] = (x + w*y) & 255;
  endtask

  task automatic set_const(input int v);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) img[y][x] = v;
  endtask

  initial begin
    rst = 1'b0; start_v = '0; sel = 0;
    cfg_relu_en = 0; cfg_pool_avg = 0; coef_valid_in = 0; coef_in = 0;
    pixel_valid_in = 0; pixel_in = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk(res[i] == 0, "reset_result", res[i], 0);
      chk(vld[i] == 0 && dn[i] == 0 && bsy[i] == 0, "reset_flags",
          {vld[i], dn[i], bsy[i]}, 0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Identity, max pool
    set_identity(); set_ramp(8, 8); m_relu = 1; m_avg = 0;
    run_frame(0, 8, 8, 0, 0, 0);
    chk(got_log[0] == 18, "id_max_r0", got_log[0], 18);
    chk(got_log[1] == 20, "id_max_r1", got_log[1], 20);
    chk(got_log[2] == 22, "id_max_r2", got_log[2], 22);
    chk(got_log[8] == 54, "id_max_r8", got_log[8], 54);
    chk(got_log.size() == 9, "id_max_count", got_log.size(), 9);

    // Identity, average pool
    m_avg = 1;
    run_frame(0, 8, 8, 0, 0, 0);
    chk(got_log[0] == 13, "id_avg_r0", got_log[0], 13);
    chk(got_log[1] == 15, "id_avg_r1", got_log[1], 15);
    chk(got_log[8] == 49, "id_avg_r8", got_log[8], 49);

    // All weights -1 on a constant image
    for (int k = 0; k < 9; k++) wt[k] = -1;
    wt[9] = 0; set_const(10); m_relu = 1; m_avg = 0;
    run_frame(0, 8, 8, 0, 0, 0);
    chk(got_log[4] == 0, "neg_relu", got_log[4], 0);
    m_relu = 0;
    run_frame(0, 8, 8, 0, 0, 0);
    chk(got_log[0] == -90, "neg_norelu", got_log[0], -90);
    wt[9] = 5;
    run_frame(0, 8, 8, 0, 0, 0);
    chk(got_log[8] == -85, "neg_bias", got_log[8], -85);

    // Odd 7x7 frame
    set_identity(); set_ramp(7, 7); m_relu = 1; m_avg = 0;
    run_frame(1, 7, 7, 0, 0, 0);
    chk(got_log.size() == 4, "odd_count", got_log.size(), 4);
    chk(got_log[0] == 16, "odd_r0", got_log[0], 16);

    // Identity with ~50% valid gaps
    set_ramp(8, 8);
    run_frame(0, 8, 8, 50, 0, 0);
    chk(got_log[8] == 54, "gap_r8", got_log[8], 54);

    // Abort mid-frame with reset, then a clean frame
    run_frame(0, 8, 8, 0, 30, 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk(res[0] == 0 && vld[0] == 0 && dn[0] == 0 && bsy[0] == 0,
          "reset_mid_frame", res[0], 0);
    end
    rst = 1'b1;
    @(negedge clk);
    run_frame(0, 8, 8, 30, 0, 0);
    chk(got_log[0] == 18, "after_reset_r0", got_log[0], 18);

    // Random weights, pixels and configuration
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 10; k++) wt[k] = int'($urandom_range(255)) - 128;
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++) img[y][x] = $urandom_range(255);
      m_relu = $urandom_range(1); m_avg = $urandom_range(1);
      run_frame(0, 8, 8, 40, 0, 0);
    end

    // Default 32x32 XOR pattern with trailing extra pixels
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) img[y][x] = 100 + (x ^ y);
    for (int k = 0; k < 10; k++) wt[k] = int'($urandom_range(255)) - 128;
    m_relu = $urandom_range(1); m_avg = $urandom_range(1);
    run_frame(2, 32, 32, 10, 0, 1);
    chk(got_log.size() == 225, "xor_count", got_log.size(), 225);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
